// File: rtl/fetch_if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if_id_pkg
// Description : Shared pipeline constants and fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_if_id_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam logic [4:0]  OP_NOP    = 5'b00001;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage : fetch_if_id_pkg
`default_nettype wire

// File: rtl/fetch_if_id_reg16_en.sv
`default_nettype none
// ============================================================================
// Module      : reg16_en
// Description : 16-bit register with load enable and synchronous reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module reg16_en #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : reg16_en
`default_nettype wire

// File: rtl/fetch_if_id.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if_id
// Description : Fetch stage (PC owner) and IF/ID pipeline register with
//               stall, redirect, memory-wait bubbles and HALT freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_if_id
    import fetch_if_id_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = fetch_if_id_pkg::RESET_PC,
    parameter logic [15:0] NOP_INSTR = fetch_if_id_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_ID,
    input  logic        branchJumpDTaken_ID,
    input  logic [15:0] target_ID,
    input  logic [15:0] Instr_mem,
    input  logic        imem_ready,
    output logic [15:0] PC_IF,
    output logic [15:0] Instruction_ID,
    output logic [15:0] PC_plus2_ID,
    output logic        valid_ID,
    output logic        halted
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         r_valid;
    logic         w_valid_next;

    logic [15:0] w_pc_q;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_pc_next;
    logic        w_pc_en;
    logic        w_ifid_en;
    logic [15:0] w_instr_next;
    logic [15:0] w_pp2_next;

    assign w_pc_plus2 = w_pc_q + 16'd2;

    // Priority: stall > redirect > halted > memory wait > normal fetch
    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_pc_en      = 1'b0;
        w_pc_next    = w_pc_q;
        w_ifid_en    = 1'b0;
        w_instr_next = NOP_INSTR;
        w_pp2_next   = 16'h0000;

        if (stall_ID) begin
            // Everything holds; a redirect seen here used stale operands.
            w_state_next = r_state;
        end else if (branchJumpDTaken_ID) begin
            w_pc_en      = 1'b1;
            w_pc_next    = target_ID;
            w_ifid_en    = 1'b1;
            w_valid_next = 1'b0;
            w_state_next = RUN;
        end else if (r_state == HALTED || !imem_ready) begin
            w_ifid_en    = 1'b1;
            w_valid_next = 1'b0;
        end else begin
            w_ifid_en    = 1'b1;
            w_instr_next = Instr_mem;
            w_pp2_next   = w_pc_plus2;
            w_valid_next = 1'b1;
            if (Instr_mem[15:11] == OP_HALT) begin
                w_state_next = HALTED;
            end else begin
                w_pc_en   = 1'b1;
                w_pc_next = w_pc_plus2;
            end
        end
    end

    reg16_en #(.RESET_VAL(RESET_PC)) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pc_en),
        .i_d  (w_pc_next),
        .o_q  (w_pc_q)
    );

    reg16_en #(.RESET_VAL(NOP_INSTR)) u_instr_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_ifid_en),
        .i_d  (w_instr_next),
        .o_q  (Instruction_ID)
    );

    reg16_en #(.RESET_VAL(16'h0000)) u_pc_plus2_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_ifid_en),
        .i_d  (w_pp2_next),
        .o_q  (PC_plus2_ID)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
        end
    end

    assign PC_IF    = w_pc_q;
    assign valid_ID = r_valid;
    assign halted   = (r_state == HALTED);

endmodule : fetch_if_id
`default_nettype wire

// File: tb/tb_fetch_if_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_if_id
// Description : Directed self-checking bench for fetch_if_id.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_if_id;

    logic        clk;
    logic        rst;
    logic        stall_ID;
    logic        branchJumpDTaken_ID;
    logic [15:0] target_ID;
    logic [15:0] Instr_mem;
    logic        imem_ready;
    logic [15:0] PC_IF;
    logic [15:0] Instruction_ID;
    logic [15:0] PC_plus2_ID;
    logic        valid_ID;
    logic        halted;

    int pass_cnt;
    int total_cnt;

    fetch_if_id dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_ID            (stall_ID),
        .branchJumpDTaken_ID (branchJumpDTaken_ID),
        .target_ID           (target_ID),
        .Instr_mem           (Instr_mem),
        .imem_ready          (imem_ready),
        .PC_IF               (PC_IF),
        .Instruction_ID      (Instruction_ID),
        .PC_plus2_ID         (PC_plus2_ID),
        .valid_ID            (valid_ID),
        .halted              (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: HALT at 0x0010, otherwise 16'hA000 | addr[10:0]
    assign Instr_mem = (PC_IF == 16'h0010) ? 16'h0000 : (16'hA000 | {5'b0, PC_IF[10:0]});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        // intentionally unused
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_ID = 1'b0; branchJumpDTaken_ID = 1'b0;
        target_ID = 16'h0000; imem_ready = 1'b1;
        step(); step();
        total_cnt++; if (PC_IF !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", PC_IF); else pass_cnt++;
        total_cnt++; if (Instruction_ID !== 16'h0800) $display("FAIL reset_instr: got %h expected 0800", Instruction_ID); else pass_cnt++;
        total_cnt++; if (PC_plus2_ID !== 16'h0000) $display("FAIL reset_pp2: got %h expected 0000", PC_plus2_ID); else pass_cnt++;
        total_cnt++; if (valid_ID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_ID); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [15:0] exp_instr [3];
        logic [15:0] exp_pp2 [3];
        exp_instr = '{16'hA000, 16'hA002, 16'hA004};
        exp_pp2   = '{16'h0002, 16'h0004, 16'h0006};
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (Instruction_ID !== exp_instr[i]) $display("FAIL seq_instr%0d: got %h expected %h", i, Instruction_ID, exp_instr[i]); else pass_cnt++;
            total_cnt++; if (PC_plus2_ID !== exp_pp2[i]) $display("FAIL seq_pp2%0d: got %h expected %h", i, PC_plus2_ID, exp_pp2[i]); else pass_cnt++;
            total_cnt++; if (valid_ID !== 1'b1) $display("FAIL seq_valid%0d: got %b expected 1", i, valid_ID); else pass_cnt++;
        end
        total_cnt++; if (PC_IF !== 16'h0006) $display("FAIL seq_pc: got %h expected 0006", PC_IF); else pass_cnt++;
    endtask

    task automatic test_stall();
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        stall_ID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (PC_IF !== 16'h0004) $display("FAIL stall_pc%0d: got %h expected 0004", i, PC_IF); else pass_cnt++;
            total_cnt++; if (Instruction_ID !== 16'hA002) $display("FAIL stall_instr%0d: got %h expected A002", i, Instruction_ID); else pass_cnt++;
            total_cnt++; if (PC_plus2_ID !== 16'h0004) $display("FAIL stall_pp2%0d: got %h expected 0004", i, PC_plus2_ID); else pass_cnt++;
        end
        stall_ID = 1'b0;
        step();
        total_cnt++; if (Instruction_ID !== 16'hA004) $display("FAIL stall_resume1: got %h expected A004", Instruction_ID); else pass_cnt++;
        step();
        total_cnt++; if (Instruction_ID !== 16'hA006) $display("FAIL stall_resume2: got %h expected A006", Instruction_ID); else pass_cnt++;
        total_cnt++; if (PC_plus2_ID !== 16'h0008) $display("FAIL stall_resume_pp2: got %h expected 0008", PC_plus2_ID); else pass_cnt++;
    endtask

    task automatic test_branch();
        branchJumpDTaken_ID = 1'b1; target_ID = 16'h0040;
        step();
        branchJumpDTaken_ID = 1'b0;
        total_cnt++; if (PC_IF !== 16'h0040) $display("FAIL br_pc: got %h expected 0040", PC_IF); else pass_cnt++;
        total_cnt++; if (Instruction_ID !== 16'h0800) $display("FAIL br_bubble: got %h expected 0800", Instruction_ID); else pass_cnt++;
        total_cnt++; if (valid_ID !== 1'b0) $display("FAIL br_valid: got %b expected 0", valid_ID); else pass_cnt++;
        total_cnt++; if (PC_plus2_ID !== 16'h0000) $display("FAIL br_pp2: got %h expected 0000", PC_plus2_ID); else pass_cnt++;
        step();
        total_cnt++; if (Instruction_ID !== 16'hA040) $display("FAIL br_target_instr: got %h expected A040", Instruction_ID); else pass_cnt++;
        total_cnt++; if (PC_plus2_ID !== 16'h0042) $display("FAIL br_target_pp2: got %h expected 0042", PC_plus2_ID); else pass_cnt++;
        stall_ID = 1'b1; branchJumpDTaken_ID = 1'b1; target_ID = 16'h0080;
        step();
        stall_ID = 1'b0; branchJumpDTaken_ID = 1'b0;
        total_cnt++; if (PC_IF !== 16'h0042) $display("FAIL br_stalled_pc: got %h expected 0042", PC_IF); else pass_cnt++;
        total_cnt++; if (Instruction_ID !== 16'hA040) $display("FAIL br_stalled_instr: got %h expected A040", Instruction_ID); else pass_cnt++;
    endtask

    task automatic test_imem_wait();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++; if (Instruction_ID !== 16'h0800) $display("FAIL wait_instr%0d: got %h expected 0800", i, Instruction_ID); else pass_cnt++;
            total_cnt++; if (valid_ID !== 1'b0) $display("FAIL wait_valid%0d: got %b expected 0", i, valid_ID); else pass_cnt++;
            total_cnt++; if (PC_IF !== 16'h0042) $display("FAIL wait_pc%0d: got %h expected 0042", i, PC_IF); else pass_cnt++;
        end
        imem_ready = 1'b1;
        step();
        total_cnt++; if (Instruction_ID !== 16'hA042) $display("FAIL wait_resume: got %h expected A042", Instruction_ID); else pass_cnt++;
        total_cnt++; if (PC_plus2_ID !== 16'h0044) $display("FAIL wait_resume_pp2: got %h expected 0044", PC_plus2_ID); else pass_cnt++;
        // Stall outranks memory wait: IF/ID keeps the real instruction
        stall_ID = 1'b1; imem_ready = 1'b0;
        step();
        stall_ID = 1'b0; imem_ready = 1'b1;
        total_cnt++; if (Instruction_ID !== 16'hA042) $display("FAIL stall_wait_instr: got %h expected A042", Instruction_ID); else pass_cnt++;
        total_cnt++; if (valid_ID !== 1'b1) $display("FAIL stall_wait_valid: got %b expected 1", valid_ID); else pass_cnt++;
    endtask

    task automatic test_halt();
        branchJumpDTaken_ID = 1'b1; target_ID = 16'h0010;
        step();
        branchJumpDTaken_ID = 1'b0;
        step();
        total_cnt++; if (Instruction_ID !== 16'h0000) $display("FAIL halt_instr: got %h expected 0000", Instruction_ID); else pass_cnt++;
        total_cnt++; if (valid_ID !== 1'b1) $display("FAIL halt_valid: got %b expected 1", valid_ID); else pass_cnt++;
        total_cnt++; if (PC_plus2_ID !== 16'h0012) $display("FAIL halt_pp2: got %h expected 0012", PC_plus2_ID); else pass_cnt++;
        total_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag: got %b expected 1", halted); else pass_cnt++;
        total_cnt++; if (PC_IF !== 16'h0010) $display("FAIL halt_pc: got %h expected 0010", PC_IF); else pass_cnt++;
        step();
        total_cnt++; if (Instruction_ID !== 16'h0800) $display("FAIL halted_nop: got %h expected 0800", Instruction_ID); else pass_cnt++;
        total_cnt++; if (valid_ID !== 1'b0) $display("FAIL halted_valid: got %b expected 0", valid_ID); else pass_cnt++;
        total_cnt++; if (PC_IF !== 16'h0010) $display("FAIL halted_pc: got %h expected 0010", PC_IF); else pass_cnt++;
        branchJumpDTaken_ID = 1'b1; target_ID = 16'h0020;
        step();
        branchJumpDTaken_ID = 1'b0;
        total_cnt++; if (halted !== 1'b0) $display("FAIL unhalt_flag: got %b expected 0", halted); else pass_cnt++;
        total_cnt++; if (PC_IF !== 16'h0020) $display("FAIL unhalt_pc: got %h expected 0020", PC_IF); else pass_cnt++;
        step();
        total_cnt++; if (Instruction_ID !== 16'hA020) $display("FAIL unhalt_fetch: got %h expected A020", Instruction_ID); else pass_cnt++;
        // Redirect while HALT sits on Instr_mem discards the HALT
        branchJumpDTaken_ID = 1'b1; target_ID = 16'h0010;
        step();
        target_ID = 16'h0030;
        step();
        branchJumpDTaken_ID = 1'b0;
        total_cnt++; if (PC_IF !== 16'h0030) $display("FAIL br_over_halt_pc: got %h expected 0030", PC_IF); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL br_over_halt_flag: got %b expected 0", halted); else pass_cnt++;
        total_cnt++; if (Instruction_ID !== 16'h0800) $display("FAIL br_over_halt_instr: got %h expected 0800", Instruction_ID); else pass_cnt++;
        // Halt again, then reset while halted
        branchJumpDTaken_ID = 1'b1; target_ID = 16'h0010;
        step();
        branchJumpDTaken_ID = 1'b0;
        step();
        total_cnt++; if (halted !== 1'b1) $display("FAIL rehalt_flag: got %b expected 1", halted); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++; if (PC_IF !== 16'h0000) $display("FAIL halt_rst_pc: got %h expected 0000", PC_IF); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL halt_rst_flag: got %b expected 0", halted); else pass_cnt++;
        total_cnt++; if (Instruction_ID !== 16'h0800) $display("FAIL halt_rst_instr: got %h expected 0800", Instruction_ID); else pass_cnt++;
    endtask

    task automatic test_wrap();
        branchJumpDTaken_ID = 1'b1; target_ID = 16'hFFFE;
        step();
        branchJumpDTaken_ID = 1'b0;
        total_cnt++; if (PC_IF !== 16'hFFFE) $display("FAIL wrap_target: got %h expected FFFE", PC_IF); else pass_cnt++;
        step();
        total_cnt++; if (Instruction_ID !== 16'hA7FE) $display("FAIL wrap_instr: got %h expected A7FE", Instruction_ID); else pass_cnt++;
        total_cnt++; if (PC_plus2_ID !== 16'h0000) $display("FAIL wrap_pp2: got %h expected 0000", PC_plus2_ID); else pass_cnt++;
        total_cnt++; if (PC_IF !== 16'h0000) $display("FAIL wrap_pc: got %h expected 0000", PC_IF); else pass_cnt++;
        total_cnt++; if (valid_ID !== 1'b1) $display("FAIL wrap_valid: got %b expected 1", valid_ID); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b1;
        stall_ID = 1'b0;
        branchJumpDTaken_ID = 1'b0;
        target_ID = 16'h0000;
        imem_ready = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_imem_wait();
        test_halt();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_fetch_if_id
`default_nettype wire
